i2c_write_slave: RTL and testbench
==================================

I2C_WRITE_SLAVE -- requirements
Module: i2c_write_slave

Interface
REQ-001 Parameter I2C_ADDR, default 7'h70, 7-bit slave address matched against the first byte after START.
REQ-002 Parameter SYNC_STAGES, default 2, input synchronizer depth for scl_in and sda_in (minimum 2).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl_in  input  1  I2C clock from pad, asynchronous.
REQ-006 sda_in  input  1  I2C data from pad, asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 wr_valid  output  1  one-cycle pulse: wr_addr/wr_data hold a completed register write.
REQ-009 wr_addr  output  8  register sub-address of the current write.
REQ-010 wr_data  output  8  data byte of the current write.
REQ-011 busy  output  1  high from a START to an own address until STOP.

Function
REQ-012 scl_in and sda_in shall pass through SYNC_STAGES flops; edge detection shall use the synchronized value and its one-cycle-delayed copy.
REQ-013 START (and repeated START) = SDA falling while SCL high; the FSM shall enter ADDR from any state, bit counter cleared.
REQ-014 STOP = SDA rising while SCL high; the FSM shall enter IDLE from any state, sda_oe released the same cycle.
REQ-015 Data bits shall be sampled on SCL rising edge, MSB first, into an 8-bit shift register; bit counter 0..7.
REQ-016 States: IDLE, ADDR, ACK_ADDR, SUB, ACK_SUB, DATA, ACK_DATA, IGNORE.
REQ-017 ADDR: after 8 bits, if byte[7:1]==I2C_ADDR and byte[0]==0 -> ACK_ADDR; otherwise (mismatch or read bit) -> IGNORE, never driving SDA.
REQ-018 ACK states: sda_oe shall assert on the SCL falling edge ending bit 8 and release on the next SCL falling edge (end of the 9th clock).
REQ-019 ACK_ADDR -> SUB; ACK_SUB -> DATA; ACK_DATA -> DATA.
REQ-020 On the 8th SUB bit, the byte shall load an internal pointer.
REQ-021 On the 8th DATA bit, wr_addr<=pointer, wr_data<=byte, wr_valid pulses exactly one cycle; pointer increments after the pulse, wrapping 8'hFF -> 8'h00.
REQ-022 wr_addr/wr_data shall hold their values until the next wr_valid.
REQ-023 IGNORE shall exit only on START or STOP.
REQ-024 STOP or START mid-byte shall discard the partial byte with no wr_valid.
REQ-025 START and STOP in the same cycle cannot occur; if both SCL and SDA edges coincide, SCL edge processing shall be suppressed that cycle.
REQ-026 The slave shall never stretch SCL and never drive SDA high.

Reset
REQ-027 On reset: FSM=IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, pointer=0, bit counter=0, synchronizer flops=1 (idle bus).
REQ-028 Reset asserted mid-transaction shall release SDA the next edge and ignore bus activity until a fresh START.

Structure
REQ-029 State enumeration and the default address constant shall live in the shared package ttrpg_dice_pkg.
REQ-030 The synchronizer plus START/STOP/SCL-edge detection shall be a sub-module i2c_bus_sync; the FSM, shift register and pointer stay in i2c_write_slave.

Verification
REQ-031 START, 0xE0, 0x0A, 0x55, 0x1F, STOP -> ACK on all 4 bytes; wr_valid twice: (0x0A,0x55) then (0x0B,0x1F).
REQ-032 START, 0xE2 (wrong address) -> no ACK, sda_oe stays 0 through all following bytes and STOP, no wr_valid.
REQ-033 START, 0xE1 (read bit) -> NAK, no wr_valid.
REQ-034 Sub-address 0xFF, two data bytes 0x01, 0x02 -> writes (0xFF,0x01) then (0x00,0x02).
REQ-035 STOP after 4 bits of a data byte -> no wr_valid, FSM IDLE, busy=0; a following full transaction writes correctly.
REQ-036 Reset pulse during ACK_SUB -> sda_oe=0 the next cycle; remaining bytes before the next START produce no ACK and no wr_valid.

Source files
------------

// File: rtl/ttrpg_dice_pkg.sv
// Shared types and constants for the I2C register-write slave.
// Holds the FSM state encoding, the default bus address and small decode helpers.
package ttrpg_dice_pkg;

    localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h70;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_SUB,
        ST_ACK_SUB,
        ST_DATA,
        ST_ACK_DATA,
        ST_IGNORE
    } i2c_state_e;

    // A write transfer to us needs our address with the R/W bit clear.
    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && !addr_byte[0];
    endfunction

    function automatic i2c_state_e next_after_ack(input i2c_state_e ack_state);
        i2c_state_e nxt;
        case (ack_state)
            ST_ACK_ADDR: nxt = ST_SUB;
            ST_ACK_SUB:  nxt = ST_DATA;
            ST_ACK_DATA: nxt = ST_DATA;
            default:     nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchronizer for SCL/SDA plus START, STOP and SCL edge detection.
// Events are single-cycle strobes in the system clock domain.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda_bit,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_scl_sync;
    logic [STAGES-1:0] r_sda_sync;
    logic              r_scl_d;
    logic              r_sda_d;

    logic w_scl;
    logic w_sda;
    logic w_sda_edge;
    logic w_scl_high;

    // Flops come out of reset at 1 so an idle bus never looks like an edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[STAGES-2:0], i_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[STAGES-1];
    assign w_sda      = r_sda_sync[STAGES-1];
    assign w_sda_edge = w_sda ^ r_sda_d;
    assign w_scl_high = w_scl & r_scl_d;

    // An SCL edge landing together with an SDA edge is ambiguous, so drop it.
    assign o_scl_rise = w_scl & ~r_scl_d & ~w_sda_edge;
    assign o_scl_fall = ~w_scl & r_scl_d & ~w_sda_edge;
    assign o_start    = w_scl_high & r_sda_d & ~w_sda;
    assign o_stop     = w_scl_high & ~r_sda_d & w_sda;
    assign o_sda_bit  = w_sda;

endmodule

// File: rtl/i2c_write_slave.sv
// Write-only I2C register slave: address, sub-address pointer, then data bytes.
// Each data byte produces a one-cycle write strobe; the pointer auto-increments.
module i2c_write_slave
    import ttrpg_dice_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = DEFAULT_I2C_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy
);

    logic w_sda_bit;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_state_e r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_byte_rdy;
    logic [7:0] r_ptr;
    logic       r_sda_oe;
    logic       r_wr_valid;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_busy;

    i2c_state_e w_state_n;
    logic [2:0] w_bit_cnt_n;
    logic [7:0] w_shift_n;
    logic       w_byte_rdy_n;
    logic [7:0] w_ptr_n;
    logic       w_sda_oe_n;
    logic       w_wr_valid_n;
    logic [7:0] w_wr_addr_n;
    logic [7:0] w_wr_data_n;
    logic       w_busy_n;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_scl      (i_scl_in),
        .i_sda      (i_sda_in),
        .o_sda_bit  (w_sda_bit),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_byte_rdy <= 1'b0;
            r_ptr      <= '0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_bit_cnt  <= w_bit_cnt_n;
            r_shift    <= w_shift_n;
            r_byte_rdy <= w_byte_rdy_n;
            r_ptr      <= w_ptr_n;
            r_sda_oe   <= w_sda_oe_n;
            r_wr_valid <= w_wr_valid_n;
            r_wr_addr  <= w_wr_addr_n;
            r_wr_data  <= w_wr_data_n;
            r_busy     <= w_busy_n;
        end
    end

    // A completed byte is acted on the cycle after its 8th bit is shifted in,
    // so decisions always see the whole byte in r_shift.
    always_comb begin
        w_state_n    = r_state;
        w_bit_cnt_n  = r_bit_cnt;
        w_shift_n    = r_shift;
        w_byte_rdy_n = 1'b0;
        w_ptr_n      = r_ptr;
        w_sda_oe_n   = r_sda_oe;
        w_wr_valid_n = 1'b0;
        w_wr_addr_n  = r_wr_addr;
        w_wr_data_n  = r_wr_data;
        w_busy_n     = r_busy;

        if (w_stop) begin
            w_state_n   = ST_IDLE;
            w_bit_cnt_n = '0;
            w_sda_oe_n  = 1'b0;
            w_busy_n    = 1'b0;
        end else if (w_start) begin
            w_state_n   = ST_ADDR;
            w_bit_cnt_n = '0;
            w_sda_oe_n  = 1'b0;
        end else if (r_byte_rdy) begin
            case (r_state)
                ST_ADDR: begin
                    if (addr_match(r_shift, I2C_ADDR)) begin
                        w_state_n = ST_ACK_ADDR;
                        w_busy_n  = 1'b1;
                    end else begin
                        w_state_n = ST_IGNORE;
                    end
                end
                ST_SUB: begin
                    w_ptr_n   = r_shift;
                    w_state_n = ST_ACK_SUB;
                end
                ST_DATA: begin
                    w_wr_addr_n  = r_ptr;
                    w_wr_data_n  = r_shift;
                    w_wr_valid_n = 1'b1;
                    w_ptr_n      = r_ptr + 8'd1;
                    w_state_n    = ST_ACK_DATA;
                end
                default: ;
            endcase
        end else begin
            case (r_state)
                ST_ADDR, ST_SUB, ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_n    = {r_shift[6:0], w_sda_bit};
                        w_bit_cnt_n  = r_bit_cnt + 3'd1;
                        w_byte_rdy_n = (r_bit_cnt == 3'd7);
                    end
                end
                // First falling edge starts the ACK slot, the second ends it.
                ST_ACK_ADDR, ST_ACK_SUB, ST_ACK_DATA: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_n = 1'b1;
                        end else begin
                            w_sda_oe_n = 1'b0;
                            w_state_n  = next_after_ack(r_state);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sda_oe   = r_sda_oe & ~w_stop;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_i2c_write_slave.sv
// Randomized scoreboard bench for i2c_write_slave with a transaction-level model.
// The stimulus side predicts writes and ACKs; a monitor pops writes as they appear.
module tb_i2c_write_slave;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclM;
    logic       sdaM;
    wire        sdaBus;
    logic       sdaOe;
    logic       wrValid;
    logic [7:0] wrAddr;
    logic [7:0] wrData;
    logic       busy;

    int nChecks = 0;
    int nPass = 0;
    int oeViolations = 0;

    logic [15:0] expQ[$];
    logic [15:0] lastWrite;
    bit          mInTxn;
    bit          mAddressed;
    bit          mBusy;
    int          mIdx;
    logic [7:0]  mPtr;

    assign sdaBus = sdaM & ~sdaOe;

    always #5 clk = ~clk;

    i2c_write_slave #(
        .I2C_ADDR    (7'h70),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_scl_in   (sclM),
        .i_sda_in   (sdaBus),
        .o_sda_oe   (sdaOe),
        .o_wr_valid (wrValid),
        .o_wr_addr  (wrAddr),
        .o_wr_data  (wrData),
        .o_busy     (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (!reset) begin
            if (wrValid) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpected_write: got %0h/%0h, expected no write", wrAddr, wrData);
                end else begin
                    checkOutput("write", {16'h0, wrAddr, wrData}, {16'h0, expQ.pop_front()});
                end
            end
            if (sdaOe && !mAddressed) oeViolations++;
        end
    end

    // Reference model: byte position within a transfer decides its meaning.
    function automatic bit modelByte(input logic [7:0] b);
        bit ack;
        ack = 1'b0;
        if (mInTxn) begin
            if (mIdx == 0) begin
                mAddressed = (b[7:1] == 7'h70) && (b[0] == 1'b0);
                if (mAddressed) mBusy = 1'b1;
                ack = mAddressed;
            end else if (!mAddressed) begin
                ack = 1'b0;
            end else if (mIdx == 1) begin
                mPtr = b;
                ack = 1'b1;
            end else begin
                expQ.push_back({mPtr, b});
                lastWrite = {mPtr, b};
                mPtr = mPtr + 8'd1;
                ack = 1'b1;
            end
            mIdx++;
        end
        return ack;
    endfunction

    task automatic waitQ();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic busStart();
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b0; waitQ();
        sclM = 1'b0; waitQ();
        mInTxn = 1'b1; mIdx = 0; mAddressed = 1'b0;
    endtask

    task automatic busStop();
        sdaM = 1'b0; waitQ();
        sclM = 1'b1; waitQ();
        sdaM = 1'b1; waitQ();
        mInTxn = 1'b0; mAddressed = 1'b0; mBusy = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sdaM = b[7-i]; waitQ();
            sclM = 1'b1; waitQ(); waitQ();
            sclM = 1'b0; waitQ();
        end
    endtask

    task automatic ackBit(output bit acked);
        sdaM = 1'b1; waitQ();
        sclM = 1'b1; waitQ();
        acked = !sdaBus; waitQ();
        sclM = 1'b0; waitQ();
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit expAck;
        bit acked;
        expAck = modelByte(b);
        sendBits(b, 8);
        ackBit(acked);
        checkOutput($sformatf("ack_%02h", b), {31'h0, acked}, {31'h0, expAck});
        checkOutput("busy", {31'h0, busy}, {31'h0, mBusy});
    endtask

    task automatic finishTxn();
        busStop();
        waitQ();
        checkOutput("idle_busy", {31'h0, busy}, 32'h0);
        checkOutput("idle_oe", {31'h0, sdaOe}, 32'h0);
        checkOutput("writes_drained", expQ.size(), 32'h0);
        checkOutput("wr_hold", {16'h0, wrAddr, wrData}, {16'h0, lastWrite});
        checkOutput("oe_violations", oeViolations, 32'h0);
    endtask

    task automatic applyStimulus();
        bit acked;
        logic [7:0] addr;
        int nData;

        // Basic two-byte write with auto-increment.
        busStart(); sendByte(8'hE0); sendByte(8'h0A); sendByte(8'h55); sendByte(8'h1F); finishTxn();

        // Wrong address: slave stays silent for the whole transfer.
        busStart(); sendByte(8'hE2); sendByte(8'h0A); sendByte(8'h66); finishTxn();

        // Read request is not acknowledged.
        busStart(); sendByte(8'hE1); finishTxn();

        // Pointer wraps from FF to 00.
        busStart(); sendByte(8'hE0); sendByte(8'hFF); sendByte(8'h01); sendByte(8'h02); finishTxn();

        // STOP in the middle of a data byte, then a clean transfer.
        busStart(); sendByte(8'hE0); sendByte(8'h30); sendByte(8'h11); sendBits(8'h5A, 4); finishTxn();
        busStart(); sendByte(8'hE0); sendByte(8'h40); sendByte(8'h99); finishTxn();

        // Repeated START in the middle of a data byte drops the partial byte.
        busStart(); sendByte(8'hE0); sendByte(8'h10); sendBits(8'hC3, 3);
        busStart(); sendByte(8'hE0); sendByte(8'h20); sendByte(8'h77); finishTxn();

        // Reset while the sub-address ACK is being driven.
        busStart(); sendByte(8'hE0);
        void'(modelByte(8'h0A));
        sendBits(8'h0A, 8);
        sdaM = 1'b1; waitQ();
        checkOutput("ack_sub_driven", {31'h0, sdaOe}, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("reset_oe", {31'h0, sdaOe}, 32'h0);
        mInTxn = 1'b0; mAddressed = 1'b0; mBusy = 1'b0; lastWrite = 16'h0;
        sclM = 1'b1; waitQ();
        acked = !sdaBus; waitQ();
        sclM = 1'b0; waitQ();
        checkOutput("ack_after_reset", {31'h0, acked}, 32'h0);
        sendByte(8'h33); sendByte(8'h44); finishTxn();

        // Randomized transfers, some truncated mid-byte.
        for (int t = 0; t < 20; t++) begin
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hE0;
            nData = $urandom_range(0, 3);
            busStart();
            sendByte(addr);
            sendByte(8'($urandom_range(0, 255)));
            for (int d = 0; d < nData; d++) sendByte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 4) == 0) sendBits(8'($urandom_range(0, 255)), $urandom_range(1, 7));
            finishTxn();
        end
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        nChecks++;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        sclM = 1'b1;
        sdaM = 1'b1;
        mInTxn = 1'b0; mAddressed = 1'b0; mBusy = 1'b0; mIdx = 0; mPtr = 8'h0;
        lastWrite = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_oe", {31'h0, sdaOe}, 32'h0);
        checkOutput("reset_valid", {31'h0, wrValid}, 32'h0);
        checkOutput("reset_addr", {24'h0, wrAddr}, 32'h0);
        checkOutput("reset_data", {24'h0, wrData}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        waitQ();
        applyStimulus();
        waitQ();
        checkOutput("final_queue", expQ.size(), 32'h0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
